ex_mem_stage: RTL
=================

# ex_mem_stage

EX/MEM pipeline stage of the RISC-V Lite core, directly downstream of the ALU. It captures the ALU result, branch-decision bit and EX control fields into the MEM-side register under a valid/ready handshake. It resolves taken branches into a one-cycle PC redirect pulse and discards the wrong-path instructions that follow the branch through EX. It also exports the registered destination and result as a forwarding source for the ALU operand muxes.

## Interface
- KILL_SLOTS, 2, number of accepted EX instructions discarded after a taken branch (1..7)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  stage accepts the EX instruction this cycle
- ex_alu_result  in  32  ALUResult
- ex_bit_branch  in  1  BIT_Branch
- ex_is_branch  in  1  instruction is a conditional branch (BNE/BLE)
- ex_branch_target  in  32  branch target PC
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  in  1 each  control bits
- mem_valid  out  1  MEM register holds a valid instruction
- mem_ready  in  1  MEM consumes the register this cycle
- mem_alu_result, mem_store_data  out  32 each  registered payload
- mem_rd  out  5; mem_reg_write, mem_mem_read, mem_mem_write  out  1 each
- redirect_valid  out  1  one-cycle taken-branch pulse
- redirect_pc  out  32  target PC, meaningful only while redirect_valid=1
- fwd_valid  out  1  equals mem_valid & mem_reg_write & (mem_rd != 0)
- fwd_rd  out  5  equals mem_rd; fwd_value  out  32  equals mem_alu_result

## Operation
- ex_ready = !mem_valid | mem_ready (combinational). accept = ex_valid & ex_ready.
- States: RUN, KILL. A 3-bit kill_cnt is used in KILL.
- RUN, accept, ex_is_branch=0: load all payload and control fields and set mem_valid=1.
- RUN, accept, ex_is_branch=1, ex_bit_branch=0: branch retires here. Set mem_valid=0 (bubble); no redirect.
- RUN, accept, ex_is_branch=1, ex_bit_branch=1: set mem_valid=0, redirect_valid=1 next cycle with redirect_pc=ex_branch_target, kill_cnt=KILL_SLOTS, go to KILL.
- ex_bit_branch is ignored when ex_is_branch=0.
- KILL, accept: discard the instruction (including a taken branch, which causes no redirect), set mem_valid=0, decrement kill_cnt. On kill_cnt reaching 0, go to RUN.
- KILL, no accept: hold state and kill_cnt.
- No accept, mem_valid & mem_ready: set mem_valid=0. Payload registers hold their last values.
- No accept, mem_valid & !mem_ready: hold all registers (stall).
- redirect_valid is cleared every cycle it is not being set. A taken branch never overlaps a pending redirect because it enters KILL.
- Reset: state=RUN, kill_cnt=0, mem_valid=0, redirect_valid=0, redirect_pc=0, all mem_* payload/control=0, so fwd_valid=0.

## Timing
- Latency: accept at edge N drives mem_* at N+1. redirect_valid is high for exactly cycle N+1 after the branch is accepted at edge N.
- ex_ready depends only on registered mem_valid and input mem_ready; no path from ex_valid.
- Simultaneous drain and accept (mem_valid & mem_ready & ex_valid) gives full throughput: the new instruction loads the same edge.
- The first instruction accepted after KILL exits (the edge where kill_cnt goes 1->0 is the last discard) is processed in RUN.
- rst mid-KILL or mid-stall: the state above applies at the next edge; a pending redirect is dropped.
- fwd_* are pure functions of registers; no combinational input-to-output path.

## Test plan
- Reset: assert rst two cycles with ex_valid=1 -> mem_valid=0, redirect_valid=0, fwd_valid=0, ex_ready=1.
- Stream: 4 back-to-back ADD results 0x10,0x20,0x30,0x40, rd=1..4, mem_ready=1 -> mem_alu_result follows one cycle later, each for one cycle; ex_ready stays 1.
- Stall: mem_ready=0 for 3 cycles with mem_alu_result=0x20 -> ex_ready=0 and payload held; at release the next value 0x30 loads on the same edge.
- Taken branch: BNE with bit_branch=1, target 0x0000_0100, then 3 ALU ops (KILL_SLOTS=2) -> redirect_valid one cycle with pc 0x100; first two ops never raise mem_valid; third appears at MEM.
- Not-taken branch: BLE with bit_branch=0 -> mem_valid=0 that cycle, no redirect, following op passes normally.
- Forwarding: ADD rd=0 result 0x5 -> fwd_valid=0; ADD rd=7 result 0xDEAD_BEEF -> fwd_valid=1, fwd_rd=7, fwd_value=0xDEAD_BEEF.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU results under valid/ready, turns taken
// branches into a one-cycle PC redirect and squashes the wrong-path slots behind them.
module ex_mem_stage #(
  parameter int unsigned KILL_SLOTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_bit_branch,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_branch_target,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_store_data,
  output logic [4:0]  mem_rd,
  output logic        mem_reg_write,
  output logic        mem_mem_read,
  output logic        mem_mem_write,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_value
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned KCNT_W  = 3;

  typedef enum logic {RUN, KILL} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
  } payload_t;

  state_t              state, state_n;
  logic [KCNT_W-1:0]   kill_cnt, kill_cnt_n;
  logic                mem_valid_n;
  logic                redirect_valid_n;
  logic [XLEN-1:0]     redirect_pc_n;
  logic                load;
  logic                accept;
  payload_t            pay_q, pay_d;

  assign ex_ready = !mem_valid || mem_ready;
  assign accept   = ex_valid && ex_ready;

  assign pay_d = '{alu_result: ex_alu_result, store_data: ex_store_data, rd: ex_rd,
                   reg_write: ex_reg_write, mem_read: ex_mem_read, mem_write: ex_mem_write};

  // Next-state, kill counter, handshake and redirect decisions
  always_comb begin
    state_n          = state;
    kill_cnt_n       = kill_cnt;
    mem_valid_n      = mem_valid && !mem_ready;
    redirect_valid_n = 1'b0;
    redirect_pc_n    = redirect_pc;
    load             = 1'b0;
    if (accept) begin
      mem_valid_n = 1'b0;
      case (state)
        RUN: begin
          if (!ex_is_branch) begin
            load        = 1'b1;
            mem_valid_n = 1'b1;
          end else if (ex_bit_branch) begin
            redirect_valid_n = 1'b1;
            redirect_pc_n    = ex_branch_target;
            kill_cnt_n       = KCNT_W'(KILL_SLOTS);
            state_n          = KILL;
          end
        end
        KILL: begin
          kill_cnt_n = kill_cnt - KCNT_W'(1);
          if (kill_cnt == KCNT_W'(1)) state_n = RUN;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      kill_cnt       <= '0;
      mem_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      pay_q          <= '0;
    end else begin
      state          <= state_n;
      kill_cnt       <= kill_cnt_n;
      mem_valid      <= mem_valid_n;
      redirect_valid <= redirect_valid_n;
      redirect_pc    <= redirect_pc_n;
      if (load) pay_q <= pay_d;
    end
  end

  assign mem_alu_result = pay_q.alu_result;
  assign mem_store_data = pay_q.store_data;
  assign mem_rd         = pay_q.rd;
  assign mem_reg_write  = pay_q.reg_write;
  assign mem_mem_read   = pay_q.mem_read;
  assign mem_mem_write  = pay_q.mem_write;

  // Forwarding source is derived from registers only
  assign fwd_valid = mem_valid && pay_q.reg_write && (pay_q.rd != '0);
  assign fwd_rd    = pay_q.rd;
  assign fwd_value = pay_q.alu_result;

endmodule
